fxp_bcd_converter: RTL and testbench
====================================

// Module: fxp_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter for calculator results. Converts a W-bit
//  integer or Qn.FRAC fixed-point value, signed or unsigned, into INT_DIGITS
//  integer digits and FRAC_DIGITS fractional digits. Integer digits use
//  shift-add-3 (double dabble); fractional digits use repeated multiply-by-10.
//  Sits between the ALU result register and the display/UART digit formatter.
// PARAMETERS
//  W           24  input width in bits
//  FRAC         8  fractional bits when i_fixed=1
//  INT_DIGITS   8  integer BCD digits
//  FRAC_DIGITS  3  fractional BCD digits, truncated (no rounding)
// PORTS
//  CLK      in   1                            clock
//  RST      in   1                            asynchronous reset, active-low
//  i_start  in   1                            start request; accepted only when o_busy=0
//  i_val    in   W                            value to convert, sampled on accept
//  i_fixed  in   1                            1: Q(W-FRAC).FRAC; 0: plain integer
//  i_signed in   1                            1: two's complement input
//  o_busy   out  1                            conversion in progress
//  o_done   out  1                            one-cycle pulse; result valid
//  o_neg    out  1                            result negative (sign for display)
//  o_ovf    out  1                            integer part exceeds INT_DIGITS
//  o_bcd    out  4*(INT_DIGITS+FRAC_DIGITS)   {int digits MS..LS, frac digits}
// BEHAVIOUR
//  Reset (RST=0, async): state IDLE; o_busy, o_done, o_neg, o_ovf = 0; o_bcd = 0.
//  FSM states: IDLE -> ABS -> INT -> FRAC -> FIN -> IDLE.
//   IDLE: i_start=1 latches i_val, i_fixed, i_signed. Next state is ABS. o_busy=1 from the next cycle.
//   ABS: neg = i_signed & i_val[W-1]. mag = neg ? -i_val : i_val, held in W bits unsigned.
//        The most negative input gives magnitude 2^(W-1). Split mag into int and frac fields.
//        Int field = mag[W-1:FRAC] when fixed, else mag. Frac field = mag[FRAC-1:0] when fixed, else none.
//   INT: one int bit per cycle. Each cycle, every digit >=5 gets +3, then shift left.
//        Takes W-FRAC cycles when fixed, W when integer. A 1 shifted out of the top
//        digit sets the sticky ovf flag.
//   FRAC: fixed only, FRAC_DIGITS cycles. f = f*10, computed as (f<<3)+(f<<1) in FRAC+4 bits.
//        Digit = f[FRAC+3:FRAC]; then f keeps f[FRAC-1:0]. Integer mode skips FRAC and
//        sets all fraction digits to 0.
//   FIN: o_bcd, o_neg and o_ovf update. o_done=1 for exactly this cycle. Next state IDLE, o_busy=0.
//  Latency from accepting cycle to o_done: fixed 3+(W-FRAC)+FRAC_DIGITS; integer 3+W.
//  With defaults: 22 cycles fixed, 27 integer.
//  Outputs hold their values until the next FIN. They do not change when a new start is accepted.
//  i_start while o_busy=1 is ignored, not queued.
//  i_start in the FIN cycle is ignored; a start is accepted only while state=IDLE.
//  Overflow: o_ovf=1 and all integer digits forced to 4'hE. Fraction digits stay valid.
//  Zero result: o_neg=0 even when the input was signed negative zero.
//  Reset mid-conversion aborts immediately. No o_done pulse follows.
// CONFIGURATION
//  LZ_BLANK_EN defined: in FIN, leading zero integer digits above the units digit become
//   `BCD_BLANK (4'hF). The units digit is always shown. Overflow digits (4'hE) are never blanked.
//  LZ_BLANK_EN undefined: leading zeros are emitted as 4'h0. Timing is identical in both builds.
// STRUCTURE
//  define.v: FSM state encodings (`BCD_IDLE..`BCD_FIN), `BCD_BLANK=4'hF, `BCD_ERR=4'hE.
//  Sub-module bcd_dabble_step (combinational): INT_DIGITS-wide add-3 adjust plus shift,
//   with a carry-out used for ovf. Instantiated once; the rest is the FSM and datapath.
// TESTING (defaults unless stated; digit groups shown MS..LS)
//  1. 24'd123456, fixed=0, signed=0 -> int 00123456, frac 000, neg=0, ovf=0.
//     o_done pulses 27 cycles after accept.
//  2. -24'sd128, fixed=0, signed=1 -> int 00000128, neg=1. Same value with signed=0
//     -> int 16777088, neg=0.
//  3. 24'h000280 (2.5 Q8), fixed=1 -> int 00000002, frac 500, done after 22 cycles.
//     24'h000001 -> frac 003 (truncated).
//  4. 24'hFFFE80 (-1.5), fixed=1, signed=1 -> int 00000001, frac 500, neg=1.
//     24'h800000 signed integer -> 08388608, neg=1.
//  5. INT_DIGITS=6 instance, 24'hFFFFFF, integer unsigned -> ovf=1, int digits all 4'hE.
//     24'd999999 -> ovf=0.
//  6. i_start pulsed mid-conversion -> ignored, one o_done only. RST=0 mid-INT -> all outputs 0,
//     no done. Restart then converts correctly. LZ_BLANK_EN build with 123456 -> FF123456.

Source files
------------

// File: rtl/fxp_bcd_converter_pkg.sv
// Shared types and constants for the fixed-point / integer to BCD converter.
// The optional leading-zero blanking build is selected with LZ_BLANK_EN.
package fxp_bcd_converter_pkg;

  typedef enum logic [2:0] {
    BCD_IDLE = 3'd0,
    BCD_ABS  = 3'd1,
    BCD_INT  = 3'd2,
    BCD_FRAC = 3'd3,
    BCD_FIN  = 3'd4
  } bcd_state_t;

  // Display codes that lie outside the decimal digit range.
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fxp_bcd_converter_dabble_step.sv
// One double-dabble iteration across a row of BCD digits: add 3 to every digit
// >= 5, then shift the whole row left by one bit, exposing the bit shifted out.
module fxp_bcd_converter_dabble_step #(
  parameter int DIGITS = 8
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                bit_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                carry_out
);

  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd_in;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i+:4] >= 4'd5) begin
        adj[4*i+:4] = bcd_in[4*i+:4] + 4'd3;
      end
    end
  end

  // A set MSB after adjustment means the value has reached 10^DIGITS.
  assign bcd_out   = {adj[4*DIGITS-2:0], bit_in};
  assign carry_out = adj[4*DIGITS-1];

endmodule

// File: rtl/fxp_bcd_converter.sv
// Sequential binary / Q(W-FRAC).FRAC to BCD converter for calculator results.
// Build option LZ_BLANK_EN: leading zero integer digits are shown as blanks.
module fxp_bcd_converter
  import fxp_bcd_converter_pkg::*;
#(
  parameter int W           = 24,
  parameter int FRAC        = 8,
  parameter int INT_DIGITS  = 8,
  parameter int FRAC_DIGITS = 3
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 i_start,
  input  logic [W-1:0]                         i_val,
  input  logic                                 i_fixed,
  input  logic                                 i_signed,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_neg,
  output logic                                 o_ovf,
  output logic [4*(INT_DIGITS+FRAC_DIGITS)-1:0] o_bcd,
  output logic [2:0]                           o_state
);

  // Handshake: a request is taken on any rising edge where i_start=1 and the FSM
  // is in IDLE (o_busy=0); o_busy then stays high until the result is published
  // together with a single-cycle o_done. Requests while busy are dropped.

  localparam int IB = 4 * INT_DIGITS;
  localparam int FB = 4 * FRAC_DIGITS;
  localparam int CW = $clog2(max_int(W, FRAC_DIGITS) + 1);

  bcd_state_t     state;
  logic [W-1:0]   val_q;
  logic           fixed_q;
  logic           signed_q;
  logic           neg_q;
  logic           ovf_q;
  logic [W-1:0]   int_sr;
  logic [FRAC-1:0] frac_f;
  logic [IB-1:0]  int_bcd;
  logic [FB-1:0]  frac_bcd;
  logic [CW-1:0]  cnt;

  logic           neg_c;
  logic [W-1:0]   mag_c;
  logic [FRAC+3:0] prod_c;
  logic [IB-1:0]  step_bcd;
  logic           step_carry;
  logic [IB-1:0]  int_disp;

  assign o_state = state;

  // Two's complement negate in W bits; the most negative input maps to 2^(W-1).
  assign neg_c = signed_q & val_q[W-1];
  assign mag_c = neg_c ? (~val_q + 1'b1) : val_q;

  // Times ten as (f<<3)+(f<<1); the top nibble is the next fraction digit.
  assign prod_c = ({4'b0000, frac_f} << 3) + ({4'b0000, frac_f} << 1);

  fxp_bcd_converter_dabble_step #(
    .DIGITS (INT_DIGITS)
  ) u_step (
    .bcd_in    (int_bcd),
    .bit_in    (int_sr[W-1]),
    .bcd_out   (step_bcd),
    .carry_out (step_carry)
  );

  always_comb begin
    int_disp = int_bcd;
`ifdef LZ_BLANK_EN
    begin : lz_blank
      logic lead;
      lead = 1'b1;
      for (int i = INT_DIGITS - 1; i >= 1; i--) begin
        if (lead && (int_bcd[4*i+:4] == 4'd0)) begin
          int_disp[4*i+:4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    if (ovf_q) begin
      int_disp = {INT_DIGITS{BCD_ERR}};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= BCD_IDLE;
      val_q    <= '0;
      fixed_q  <= 1'b0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      int_sr   <= '0;
      frac_f   <= '0;
      int_bcd  <= '0;
      frac_bcd <= '0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_neg    <= 1'b0;
      o_ovf    <= 1'b0;
      o_bcd    <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        BCD_IDLE: begin
          if (i_start) begin
            val_q    <= i_val;
            fixed_q  <= i_fixed;
            signed_q <= i_signed;
            o_busy   <= 1'b1;
            state    <= BCD_ABS;
          end
        end
        BCD_ABS: begin
          neg_q    <= neg_c;
          ovf_q    <= 1'b0;
          int_bcd  <= '0;
          frac_bcd <= '0;
          if (fixed_q) begin
            // Left-align the integer field so the dabble always consumes int_sr MSB.
            int_sr <= {mag_c[W-1:FRAC], {FRAC{1'b0}}};
            frac_f <= mag_c[FRAC-1:0];
            cnt    <= CW'(W - FRAC);
          end else begin
            int_sr <= mag_c;
            frac_f <= '0;
            cnt    <= CW'(W);
          end
          state <= BCD_INT;
        end
        BCD_INT: begin
          int_bcd <= step_bcd;
          int_sr  <= int_sr << 1;
          if (step_carry) begin
            ovf_q <= 1'b1;
          end
          if (cnt == CW'(1)) begin
            if (fixed_q) begin
              cnt   <= CW'(FRAC_DIGITS);
              state <= BCD_FRAC;
            end else begin
              state <= BCD_FIN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BCD_FRAC: begin
          frac_bcd <= FB'({frac_bcd, prod_c[FRAC+3:FRAC]});
          frac_f   <= prod_c[FRAC-1:0];
          if (cnt == CW'(1)) begin
            state <= BCD_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BCD_FIN: begin
          o_bcd  <= {int_disp, frac_bcd};
          o_ovf  <= ovf_q;
          // A result that prints as all zeros never carries a minus sign.
          o_neg  <= neg_q & (ovf_q | (|int_bcd) | (|frac_bcd));
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= BCD_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= BCD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_bcd_converter.sv
// Directed bench for fxp_bcd_converter: a default instance and a 6-digit
// instance share one stimulus stream; results checked with immediate assertions.
module tb_fxp_bcd_converter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] val;
  logic        fixed;
  logic        sgn;

  logic        busy, done, neg, ovf;
  logic [43:0] bcd;
  logic [2:0]  st;
  logic        busy6, done6, neg6, ovf6;
  logic [35:0] bcd6;
  logic [2:0]  st6;

  int n_cmp;
  int n_err;
  int lat;
  int done_cnt;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fxp_bcd_converter dut (
    .CLK (clk), .RST (rst_n), .i_start (start), .i_val (val),
    .i_fixed (fixed), .i_signed (sgn), .o_busy (busy), .o_done (done),
    .o_neg (neg), .o_ovf (ovf), .o_bcd (bcd), .o_state (st)
  );

  fxp_bcd_converter #(.INT_DIGITS (6)) dut6 (
    .CLK (clk), .RST (rst_n), .i_start (start), .i_val (val),
    .i_fixed (fixed), .i_signed (sgn), .o_busy (busy6), .o_done (done6),
    .o_neg (neg6), .o_ovf (ovf6), .o_bcd (bcd6), .o_state (st6)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected integer digit field as the display build presents it.
  function automatic logic [31:0] lz(input logic [31:0] x, input int nd);
    logic [31:0] r;
    r = x;
`ifdef LZ_BLANK_EN
    for (int i = nd - 1; i >= 1; i--) begin
      if (r[4*i+:4] == 4'h0) r[4*i+:4] = 4'hF;
      else break;
    end
`else
    if (nd < 0) r = '0;
`endif
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run(input logic [23:0] v, input logic fx, input logic sg);
    @(negedge clk);
    val = v; fixed = fx; sgn = sg; start = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic chk_main(input string tag, input logic [31:0] ei, input logic [11:0] ef,
                          input logic en, input int el);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_bcd"}, bcd, {lz(ei, 8), ef});
    chk({tag, "_neg"}, neg, en);
    chk({tag, "_ovf"}, ovf, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; val = '0; fixed = 1'b0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bcd", bcd, 44'h0);
    chk("rst_negovf", {neg, ovf}, 2'b00);
    chk("rst_state", st, 3'd0);
    @(negedge clk) rst_n = 1'b1;

    run(24'd123456, 1'b0, 1'b0);
    chk_main("int_123456", 32'h00123456, 12'h000, 1'b0, 27);

    run(24'hFFFF80, 1'b0, 1'b1);
    chk_main("int_m128", 32'h00000128, 12'h000, 1'b1, 27);
    run(24'hFFFF80, 1'b0, 1'b0);
    chk_main("uint_fff80", 32'h16777088, 12'h000, 1'b0, 27);

    run(24'h000280, 1'b1, 1'b0);
    chk_main("fx_2p5", 32'h00000002, 12'h500, 1'b0, 22);
    run(24'h000001, 1'b1, 1'b0);
    chk_main("fx_lsb", 32'h00000000, 12'h003, 1'b0, 22);
    run(24'hFFFFFF, 1'b1, 1'b0);
    chk_main("fx_max", 32'h00065535, 12'h996, 1'b0, 22);

    run(24'hFFFE80, 1'b1, 1'b1);
    chk_main("fx_m1p5", 32'h00000001, 12'h500, 1'b1, 22);
    run(24'h800000, 1'b0, 1'b1);
    chk_main("int_minneg", 32'h08388608, 12'h000, 1'b1, 27);
    run(24'h000000, 1'b1, 1'b1);
    chk_main("fx_zero", 32'h00000000, 12'h000, 1'b0, 22);

    // Six-digit instance: overflow forces E digits, then clears on the next result.
    run(24'hFFFFFF, 1'b0, 1'b0);
    chk_main("int_max", 32'h16777215, 12'h000, 1'b0, 27);
    chk("d6_ovf_flag", ovf6, 1'b1);
    chk("d6_ovf_bcd", bcd6, 36'hEEEEEE000);
    chk("d6_ovf_neg", neg6, 1'b0);
    run(24'd999999, 1'b0, 1'b0);
    chk_main("int_999999", 32'h00999999, 12'h000, 1'b0, 27);
    chk("d6_999999_ovf", ovf6, 1'b0);
    chk("d6_999999_bcd", bcd6, {lz(32'h00999999, 6), 12'h000} & 36'hFFFFFFFFF);
    chk("d6_999999_done", done6, 1'b1);

    // Starts while busy are dropped; outputs hold until the new result lands.
    @(negedge clk);
    val = 24'd42; fixed = 1'b0; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", busy, 1'b1);
    chk("hold_bcd", bcd, {lz(32'h00999999, 8), 12'h000});
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    val = 24'd7; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("ignore_start_dones", done_cnt, 1);
    chk("ignore_start_bcd", bcd, {lz(32'h00000042, 8), 12'h000});

    // Reset in the middle of the integer phase aborts without a done pulse.
    @(negedge clk);
    val = 24'd12345; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_state", st, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd, 44'h0);
    chk("mid_rst_flags", {busy, done, neg, ovf}, 4'b0000);
    chk("mid_rst_state", st, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("post_rst_no_done", done_cnt, 0);
    run(24'd123456, 1'b0, 1'b0);
    chk_main("restart_123456", 32'h00123456, 12'h000, 1'b0, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
